hid_multi: RTL and testbench

Parametrised successor HID interface between the IO MCU byte link and the core. It decodes MCU command packets for status, keyboard, mouse, digital/analog joysticks and local DB9 readback. It generalises the joystick and DB9 port count, buffers keyboard events in a FIFO with a ready/valid handshake, and accumulates mouse motion with saturation. It sits between the MCU SPI/byte receiver and the machine-specific keymap, mouse and joystick logic.

---
 rtl/hid_multi.sv | 269 ++++++++++++++++++++++++++
 tb/tb_hid_multi.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hid_multi.sv
// hid_multi: decodes MCU command packets (status, keyboard, mouse, joysticks,
// DB9 readback) into per-device registers, a keyboard event FIFO with a
// ready/valid head, and mouse motion outputs.
// Build option: define HID_MOUSE_ACCUM_EN for saturating mouse accumulation
// with mouse_rd clear; otherwise each packet loads the raw delta.
module hid_multi #(
    parameter int NUM_JOY        = 2,
    parameter int NUM_DB9        = 1,
    parameter int KBD_FIFO_DEPTH = 8,
    parameter int MOUSE_W        = 10
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   data_in_strobe,
    input  logic                   data_in_start,
    input  logic [7:0]             data_in,
    output logic [7:0]             data_out,
    input  logic [6*NUM_DB9-1:0]   db9_port,
    output logic                   irq,
    input  logic                   iack,
    output logic [8*NUM_JOY-1:0]   joystick,
    output logic [8*NUM_JOY-1:0]   joystick_ax,
    output logic [8*NUM_JOY-1:0]   joystick_ay,
    output logic [8*NUM_JOY-1:0]   extra_button,
    output logic                   joystick_strobe,
    output logic [2:0]             joystick_id,
    output logic                   key_valid,
    output logic [6:0]             key_code,
    output logic                   key_pressed,
    input  logic                   key_ready,
    output logic                   key_overflow,
    output logic [2:0]             mouse_btns,
    output logic [MOUSE_W-1:0]     mouse_dx,
    output logic [MOUSE_W-1:0]     mouse_dy,
    input  logic                   mouse_rd,
    output logic                   mouse_strobe
);
    localparam int AW = $clog2(KBD_FIFO_DEPTH);

    logic [3:0]           state_q, state_d;
    logic [7:0]           command_q, command_d;
    logic [7:0]           data_out_q, data_out_d;
    logic [7:0]           device_q, device_d;
    logic                 ovf_q, ovf_d;
    logic                 irq_q, irq_d;
    logic                 irq_en_q, irq_en_d;
    logic [6*NUM_DB9-1:0] db9_s1_q, db9_s2_q;
    logic                 joy_strobe_q, joy_strobe_d;
    logic [2:0]           joy_id_q, joy_id_d;
    logic [3:0]           joy_wr;
    logic                 dev_ok;
    logic [2:0]           btns_q, btns_d;
    logic [7:0]           dx_raw_q, dx_raw_d;
    logic [MOUSE_W-1:0]   dx_q, dx_d, dy_q, dy_d;
    logic                 mstrobe_q, mstrobe_d;
    logic                 mouse_upd;
    logic                 push_req, push, pop, full, empty;
    logic [AW:0]          wr_ptr_q, rd_ptr_q;
    logic [7:0]           fifo_mem [KBD_FIFO_DEPTH];
    logic [7:0]           head;
    logic [5:0]           db9_sel;

    assign dev_ok = device_q < 8'(NUM_JOY);
    assign empty  = wr_ptr_q == rd_ptr_q;
    assign full   = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop    = !empty && key_ready;
    // A full FIFO still accepts a push when the consumer frees a slot this cycle.
    assign push   = push_req && (!full || pop);
    assign head   = fifo_mem[rd_ptr_q[AW-1:0]];

    // Select the synchronised DB9 port addressed by the current byte index.
    always_comb begin
        db9_sel = 6'h00;
        for (int k = 0; k < NUM_DB9; k++) begin
            if (state_q == 4'(k)) db9_sel = db9_s2_q[6*k +: 6];
        end
    end

    // Command decoder: byte counter, reply byte, FIFO push, IRQ and mouse control.
    always_comb begin
        state_d      = state_q;
        command_d    = command_q;
        data_out_d   = data_out_q;
        device_d     = device_q;
        ovf_d        = ovf_q;
        irq_d        = irq_q;
        irq_en_d     = irq_en_q;
        joy_strobe_d = 1'b0;
        joy_id_d     = joy_id_q;
        joy_wr       = 4'b0000;
        btns_d       = btns_q;
        dx_raw_d     = dx_raw_q;
        mouse_upd    = 1'b0;
        push_req     = 1'b0;

        if (irq_en_q && (db9_s2_q != db9_s1_q)) begin
            irq_d    = 1'b1;
            irq_en_d = 1'b0;
        end

        if (data_in_strobe && data_in_start) begin
            state_d   = 4'd0;
            command_d = data_in;
        end else if (data_in_strobe) begin
            case (command_q)
                8'h00: begin
                    if (state_q == 4'd0) data_out_d = 8'h02;
                    else if (state_q == 4'd1) data_out_d = {ovf_q, 3'b000, 4'(NUM_JOY)};
                    else if (state_q == 4'd2) begin
                        data_out_d = 8'(NUM_DB9);
                        ovf_d      = 1'b0;
                    end
                end
                8'h01: push_req = 1'b1;
                8'h02: begin
                    if (state_q == 4'd0) btns_d = data_in[2:0];
                    else if (state_q == 4'd1) dx_raw_d = data_in;
                    else if (state_q == 4'd2) mouse_upd = 1'b1;
                end
                8'h03: begin
                    if (state_q == 4'd0) device_d = data_in;
                    else if (state_q <= 4'd4 && dev_ok) begin
                        joy_wr[state_q[1:0] - 2'd1] = 1'b1;
                        if (state_q == 4'd4) begin
                            joy_strobe_d = 1'b1;
                            joy_id_d     = device_q[2:0];
                        end
                    end
                end
                8'h04: begin
                    if (state_q == 4'd0) irq_en_d = 1'b1;
                    data_out_d = {2'b00, db9_sel};
                end
                default: ;
            endcase
            state_d = (state_q == 4'd15) ? 4'd15 : state_q + 4'd1;
        end

        if (push_req && full && !pop) ovf_d = 1'b1;
        if (iack) irq_d = 1'b0;
    end

`ifdef HID_MOUSE_ACCUM_EN
    function automatic logic [MOUSE_W-1:0] sat(input logic signed [MOUSE_W:0] s);
        if (s[MOUSE_W] != s[MOUSE_W-1])
            return s[MOUSE_W] ? {1'b1, {(MOUSE_W-1){1'b0}}} : {1'b0, {(MOUSE_W-1){1'b1}}};
        return s[MOUSE_W-1:0];
    endfunction

    logic signed [MOUSE_W:0] base_x, base_y;

    // Saturating accumulation; a same-cycle read restarts from the new delta.
    always_comb begin
        base_x = mouse_rd ? '0 : $signed({dx_q[MOUSE_W-1], dx_q});
        base_y = mouse_rd ? '0 : $signed({dy_q[MOUSE_W-1], dy_q});
        dx_d   = dx_q;
        dy_d   = dy_q;
        if (mouse_upd) begin
            dx_d = sat(base_x + (MOUSE_W+1)'($signed(dx_raw_q)));
            dy_d = sat(base_y + (MOUSE_W+1)'($signed(data_in)));
        end else if (mouse_rd) begin
            dx_d = '0;
            dy_d = '0;
        end
    end
`else
    wire unused_mouse_rd = mouse_rd;

    // Raw mode: each packet loads the sign-extended delta.
    always_comb begin
        dx_d = dx_q;
        dy_d = dy_q;
        if (mouse_upd) begin
            dx_d = MOUSE_W'($signed(dx_raw_q));
            dy_d = MOUSE_W'($signed(data_in));
        end
    end
`endif
    assign mstrobe_d = mouse_upd;

    // Control and status registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= '0;
            command_q    <= '0;
            data_out_q   <= '0;
            device_q     <= '0;
            ovf_q        <= 1'b0;
            irq_q        <= 1'b0;
            irq_en_q     <= 1'b0;
            db9_s1_q     <= '0;
            db9_s2_q     <= '0;
            joy_strobe_q <= 1'b0;
            joy_id_q     <= '0;
            btns_q       <= '0;
            dx_raw_q     <= '0;
            dx_q         <= '0;
            dy_q         <= '0;
            mstrobe_q    <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
        end else begin
            state_q      <= state_d;
            command_q    <= command_d;
            data_out_q   <= data_out_d;
            device_q     <= device_d;
            ovf_q        <= ovf_d;
            irq_q        <= irq_d;
            irq_en_q     <= irq_en_d;
            db9_s1_q     <= db9_port;
            db9_s2_q     <= db9_s1_q;
            joy_strobe_q <= joy_strobe_d;
            joy_id_q     <= joy_id_d;
            btns_q       <= btns_d;
            dx_raw_q     <= dx_raw_d;
            dx_q         <= dx_d;
            dy_q         <= dy_d;
            mstrobe_q    <= mstrobe_d;
            if (push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
        end
    end

    // Keyboard event storage; entries are {code, pressed}.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_q[AW-1:0]] <= {data_in[6:0], data_in[7]};
    end

    genvar gi;
    for (gi = 0; gi < NUM_JOY; gi++) begin : g_joy
        logic [7:0] joy_q, ax_q, ay_q, extra_q;
        logic       hit;
        assign hit = device_q == 8'(gi);

        // Per-device joystick record registers.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                joy_q   <= '0;
                ax_q    <= '0;
                ay_q    <= '0;
                extra_q <= '0;
            end else if (hit) begin
                if (joy_wr[0]) joy_q   <= data_in;
                if (joy_wr[1]) ax_q    <= data_in;
                if (joy_wr[2]) ay_q    <= data_in;
                if (joy_wr[3]) extra_q <= data_in;
            end
        end

        assign joystick[8*gi +: 8]     = joy_q;
        assign joystick_ax[8*gi +: 8]  = ax_q;
        assign joystick_ay[8*gi +: 8]  = ay_q;
        assign extra_button[8*gi +: 8] = extra_q;
    end

    assign data_out        = data_out_q;
    assign irq             = irq_q;
    assign joystick_strobe = joy_strobe_q;
    assign joystick_id     = joy_id_q;
    assign key_valid       = !empty;
    assign key_code        = empty ? 7'h00 : head[7:1];
    assign key_pressed     = !empty && head[0];
    assign key_overflow    = ovf_q;
    assign mouse_btns      = btns_q;
    assign mouse_dx        = dx_q;
    assign mouse_dy        = dy_q;
    assign mouse_strobe    = mstrobe_q;
endmodule

// File: tb/tb_hid_multi.sv
// Directed bench for hid_multi with default parameters.
module tb_hid_multi;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        data_in_strobe = 1'b0;
    logic        data_in_start = 1'b0;
    logic [7:0]  data_in = 8'h00;
    logic [7:0]  data_out;
    logic [5:0]  db9_port = 6'h00;
    logic        irq;
    logic        iack = 1'b0;
    logic [15:0] joystick, joystick_ax, joystick_ay, extra_button;
    logic        joystick_strobe;
    logic [2:0]  joystick_id;
    logic        key_valid;
    logic [6:0]  key_code;
    logic        key_pressed;
    logic        key_ready = 1'b0;
    logic        key_overflow;
    logic [2:0]  mouse_btns;
    logic [9:0]  mouse_dx, mouse_dy;
    logic        mouse_rd = 1'b0;
    logic        mouse_strobe;

    int total = 0;
    int bad = 0;

    hid_multi dut (
        .clk(clk), .reset(reset),
        .data_in_strobe(data_in_strobe), .data_in_start(data_in_start),
        .data_in(data_in), .data_out(data_out),
        .db9_port(db9_port), .irq(irq), .iack(iack),
        .joystick(joystick), .joystick_ax(joystick_ax),
        .joystick_ay(joystick_ay), .extra_button(extra_button),
        .joystick_strobe(joystick_strobe), .joystick_id(joystick_id),
        .key_valid(key_valid), .key_code(key_code), .key_pressed(key_pressed),
        .key_ready(key_ready), .key_overflow(key_overflow),
        .mouse_btns(mouse_btns), .mouse_dx(mouse_dx), .mouse_dy(mouse_dy),
        .mouse_rd(mouse_rd), .mouse_strobe(mouse_strobe)
    );

    always #5 clk = ~clk;

    task automatic send(input logic st, input logic [7:0] b);
        @(negedge clk);
        data_in_strobe = 1'b1;
        data_in_start  = st;
        data_in        = b;
        @(negedge clk);
        data_in_strobe = 1'b0;
        data_in_start  = 1'b0;
        $display("send start=%0d byte=%02h data_out=%02h", st, b, data_out);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic pop();
        @(negedge clk);
        key_ready = 1'b1;
        @(negedge clk);
        key_ready = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if ({data_out, joystick, key_valid, key_overflow, irq, mouse_dx, mouse_btns, joystick_strobe, mouse_strobe} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got do=%02h joy=%04h kv=%0d irq=%0d dx=%03h want all zero",
                     data_out, joystick, key_valid, irq, mouse_dx);
        end
    endtask

    task automatic test_status();
        logic [7:0] exp [3] = '{8'h02, 8'h02, 8'h01};
        send(1'b1, 8'h00);
        for (int i = 0; i < 3; i++) begin
            send(1'b0, 8'hAA);
            total++;
            if (data_out !== exp[i]) begin
                bad++;
                $display("FAIL status_%0d: got %02h want %02h", i, data_out, exp[i]);
            end
        end
        send(1'b1, 8'h09);
        send(1'b0, 8'h55);
        total++;
        if (data_out !== 8'h01) begin
            bad++;
            $display("FAIL unknown_cmd_hold: got %02h want 01", data_out);
        end
    endtask

    task automatic test_joystick();
        send(1'b1, 8'h03); send(1'b0, 8'h00);
        send(1'b0, 8'h11); send(1'b0, 8'h22); send(1'b0, 8'h33); send(1'b0, 8'h44);
        total++;
        if ({joystick_strobe, joystick, joystick_ax, joystick_id} !== {1'b1, 16'h0011, 16'h0022, 3'd0}) begin
            bad++;
            $display("FAIL joy_dev0: got stb=%0d joy=%04h ax=%04h id=%0d want 1 0011 0022 0",
                     joystick_strobe, joystick, joystick_ax, joystick_id);
        end
        send(1'b1, 8'h03); send(1'b0, 8'h01);
        do_reset();
        total++;
        if ({joystick, joystick_ax, joystick_ay, extra_button, joystick_strobe} !== '0) begin
            bad++;
            $display("FAIL joy_reset_mid: got joy=%04h ax=%04h stb=%0d want 0",
                     joystick, joystick_ax, joystick_strobe);
        end
        send(1'b1, 8'h03); send(1'b0, 8'h01);
        send(1'b0, 8'hA5); send(1'b0, 8'h5A); send(1'b0, 8'h3C);
        total++;
        if (joystick_strobe !== 1'b0) begin
            bad++;
            $display("FAIL joy_early_strobe: got %0d want 0", joystick_strobe);
        end
        send(1'b0, 8'hC3);
        total++;
        if ({joystick, joystick_ax, joystick_ay, extra_button, joystick_strobe, joystick_id} !==
            {16'hA500, 16'h5A00, 16'h3C00, 16'hC300, 1'b1, 3'd1}) begin
            bad++;
            $display("FAIL joy_dev1: got joy=%04h ax=%04h ay=%04h ex=%04h stb=%0d id=%0d want A500 5A00 3C00 C300 1 1",
                     joystick, joystick_ax, joystick_ay, extra_button, joystick_strobe, joystick_id);
        end
        @(negedge clk);
        total++;
        if (joystick_strobe !== 1'b0) begin
            bad++;
            $display("FAIL joy_strobe_width: got %0d want 0", joystick_strobe);
        end
    endtask

    task automatic test_bad_device();
        send(1'b1, 8'h03); send(1'b0, 8'h07);
        for (int i = 0; i < 4; i++) send(1'b0, 8'hFF);
        total++;
        if ({joystick, extra_button, joystick_strobe, joystick_id} !== {16'hA500, 16'hC300, 1'b0, 3'd1}) begin
            bad++;
            $display("FAIL joy_bad_dev: got joy=%04h ex=%04h stb=%0d id=%0d want A500 C300 0 1",
                     joystick, extra_button, joystick_strobe, joystick_id);
        end
    endtask

    task automatic test_key_overflow();
        logic [6:0] exp [8] = '{7'd1, 7'd2, 7'd3, 7'd4, 7'd5, 7'd6, 7'd7, 7'd9};
        send(1'b1, 8'h01);
        for (int i = 0; i < 9; i++) send(1'b0, 8'(i));
        total++;
        if ({key_overflow, key_valid, key_code} !== {1'b1, 1'b1, 7'd0}) begin
            bad++;
            $display("FAIL key_overflow_set: got ovf=%0d kv=%0d code=%02h want 1 1 00",
                     key_overflow, key_valid, key_code);
        end
        send(1'b1, 8'h00); send(1'b0, 8'h00); send(1'b0, 8'h00);
        total++;
        if (data_out !== 8'h82) begin
            bad++;
            $display("FAIL status_ovf_bit: got %02h want 82", data_out);
        end
        send(1'b0, 8'h00);
        total++;
        if (key_overflow !== 1'b0 || data_out !== 8'h01) begin
            bad++;
            $display("FAIL key_overflow_clear: got ovf=%0d do=%02h want 0 01", key_overflow, data_out);
        end
        send(1'b1, 8'h01);
        @(negedge clk);
        data_in_strobe = 1'b1; data_in = 8'h09; key_ready = 1'b1;
        @(negedge clk);
        data_in_strobe = 1'b0; key_ready = 1'b0;
        total++;
        if (key_overflow !== 1'b0 || key_code !== 7'd1) begin
            bad++;
            $display("FAIL key_full_push_pop: got ovf=%0d code=%02h want 0 01", key_overflow, key_code);
        end
        for (int i = 0; i < 8; i++) begin
            total++;
            if ({key_valid, key_code, key_pressed} !== {1'b1, exp[i], 1'b0}) begin
                bad++;
                $display("FAIL key_drain_%0d: got kv=%0d code=%02h p=%0d want 1 %02h 0",
                         i, key_valid, key_code, key_pressed, exp[i]);
            end
            pop();
        end
        total++;
        if (key_valid !== 1'b0) begin
            bad++;
            $display("FAIL key_empty: got %0d want 0", key_valid);
        end
    endtask

    task automatic test_key_order();
        send(1'b1, 8'h01); send(1'b0, 8'h84); send(1'b0, 8'h04);
        @(negedge clk);
        @(negedge clk);
        total++;
        if ({key_valid, key_code, key_pressed} !== {1'b1, 7'h04, 1'b1}) begin
            bad++;
            $display("FAIL key_first_held: got kv=%0d code=%02h p=%0d want 1 04 1", key_valid, key_code, key_pressed);
        end
        pop();
        total++;
        if ({key_valid, key_code, key_pressed} !== {1'b1, 7'h04, 1'b0}) begin
            bad++;
            $display("FAIL key_second: got kv=%0d code=%02h p=%0d want 1 04 0", key_valid, key_code, key_pressed);
        end
        pop();
    endtask

    task automatic test_mouse();
        logic [9:0] exp_dx;
`ifdef HID_MOUSE_ACCUM_EN
        exp_dx = 10'd511;
`else
        exp_dx = 10'd127;
`endif
        for (int i = 0; i < 5; i++) begin
            send(1'b1, 8'h02); send(1'b0, 8'h05); send(1'b0, 8'h7F);
            total++;
            if (mouse_strobe !== 1'b0) begin
                bad++;
                $display("FAIL mouse_early_strobe_%0d: got 1 want 0", i);
            end
            send(1'b0, 8'h00);
            total++;
            if (mouse_strobe !== 1'b1) begin
                bad++;
                $display("FAIL mouse_strobe_%0d: got 0 want 1", i);
            end
        end
        total++;
        if ({mouse_dx, mouse_dy, mouse_btns} !== {exp_dx, 10'd0, 3'd5}) begin
            bad++;
            $display("FAIL mouse_accum: got dx=%03h dy=%03h b=%0d want %03h 000 5", mouse_dx, mouse_dy, mouse_btns, exp_dx);
        end
        send(1'b1, 8'h02); send(1'b0, 8'h01); send(1'b0, 8'hFD);
        @(negedge clk);
        data_in_strobe = 1'b1; data_in = 8'h02; mouse_rd = 1'b1;
        @(negedge clk);
        data_in_strobe = 1'b0; mouse_rd = 1'b0;
        total++;
        if ({mouse_dx, mouse_dy, mouse_btns, mouse_strobe} !== {10'h3FD, 10'h002, 3'd1, 1'b1}) begin
            bad++;
            $display("FAIL mouse_rd_update: got dx=%03h dy=%03h b=%0d stb=%0d want 3FD 002 1 1",
                     mouse_dx, mouse_dy, mouse_btns, mouse_strobe);
        end
`ifdef HID_MOUSE_ACCUM_EN
        exp_dx = 10'h000;
`else
        exp_dx = 10'h3FD;
`endif
        @(negedge clk); mouse_rd = 1'b1;
        @(negedge clk); mouse_rd = 1'b0;
        total++;
        if (mouse_dx !== exp_dx) begin
            bad++;
            $display("FAIL mouse_rd_only: got %03h want %03h", mouse_dx, exp_dx);
        end
    endtask

    task automatic test_db9();
        @(negedge clk); db9_port = 6'h2A;
        repeat (3) @(negedge clk);
        send(1'b1, 8'h04); send(1'b0, 8'h00);
        total++;
        if (data_out !== 8'h2A || irq !== 1'b0) begin
            bad++;
            $display("FAIL db9_read0: got do=%02h irq=%0d want 2A 0", data_out, irq);
        end
        send(1'b0, 8'h00);
        total++;
        if (data_out !== 8'h00) begin
            bad++;
            $display("FAIL db9_read_oob: got %02h want 00", data_out);
        end
        @(negedge clk); db9_port = 6'h2B;
        @(negedge clk);
        total++;
        if (irq !== 1'b0) begin
            bad++;
            $display("FAIL db9_irq_early: got 1 want 0");
        end
        repeat (2) @(negedge clk);
        total++;
        if (irq !== 1'b1) begin
            bad++;
            $display("FAIL db9_irq_set: got 0 want 1");
        end
        @(negedge clk); iack = 1'b1;
        @(negedge clk); iack = 1'b0;
        total++;
        if (irq !== 1'b0) begin
            bad++;
            $display("FAIL db9_iack: got 1 want 0");
        end
        db9_port = 6'h2A;
        repeat (5) @(negedge clk);
        total++;
        if (irq !== 1'b0) begin
            bad++;
            $display("FAIL db9_irq_disarmed: got 1 want 0");
        end
    endtask

    initial begin
        test_reset();
        test_status();
        test_joystick();
        test_bad_device();
        test_key_overflow();
        test_key_order();
        test_mouse();
        test_db9();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
